// File: rtl/acc_arb_pkg.sv
// rtl/acc_arb_pkg.sv - shared types and round-robin pick helper for acc_share_arbiter
package acc_arb_pkg;

   localparam int MAX_REQ = 8;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   typedef logic [15:0] ratio_t;

   // First set bit of valid[n-1:0] searching upward from ptr with wrap.
   // Walking the offsets from high to low lets the lowest offset win last.
   function automatic logic rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr,
                                    input int n, output int idx);
      int cand;
      rr_pick = 1'b0;
      idx     = 0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (i < n) begin
            cand = ptr + i;
            if (cand >= n) cand = cand - n;
            if (valid[cand[2:0]]) begin
               rr_pick = 1'b1;
               idx     = cand;
            end
         end
      end
   endfunction

endpackage

// File: rtl/acc_rr_picker.sv
// rtl/acc_rr_picker.sv - combinational round-robin priority pick over N_REQ requesters
module acc_rr_picker
   import acc_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         valid,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     found
);

   localparam int IW = $clog2(N_REQ);

   logic [MAX_REQ-1:0] valid_ext;
   int                 pick_i;

   // Widen to the helper's fixed width and map the integer pick back onto the index bus.
   always_comb begin
      valid_ext              = '0;
      valid_ext[N_REQ-1:0]   = valid;
      pick_i                 = 0;
      found                  = rr_pick(valid_ext, int'(ptr), N_REQ, pick_i);
      idx                    = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (pick_i == j) idx = IW'(j);
      end
   end

endmodule

// File: rtl/acc_share_arbiter.sv
// rtl/acc_share_arbiter.sv - job-granular round-robin share of one accelerator; watchdog under ACC_SHARE_ARB_TIMEOUT_EN
module acc_share_arbiter
   import acc_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [15:0]                ser_ratio,
   input  logic [15:0]                deser_ratio,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   output logic [N_REQ-1:0]           rsp_valid,
   input  logic [N_REQ-1:0]           rsp_ready,
   output logic [DATA_W-1:0]          rsp_data,
   output logic                       acc_in_valid,
   input  logic                       acc_in_ready,
   output logic [DATA_W-1:0]          acc_in_data,
   input  logic                       acc_out_valid,
   output logic                       acc_out_ready,
   input  logic [DATA_W-1:0]          acc_out_data,
   output logic                       busy,
   output logic [$clog2(N_REQ)-1:0]   gnt_idx,
   output logic                       err_timeout
);

   localparam int IW = $clog2(N_REQ);

   arb_state_t     state;
   logic [IW-1:0]  rr_ptr;
   logic [IW-1:0]  pick_idx;
   logic           pick_found;
   logic [IW-1:0]  next_ptr;
   ratio_t         ser_lat, deser_lat, s_cnt, d_cnt;
   logic           in_hs, out_hs;
   logic           wd_expire;

   acc_rr_picker #(.N_REQ(N_REQ)) u_picker (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign busy     = (state == FEED) || (state == DRAIN);
   assign in_hs    = (state == FEED) && acc_in_valid && acc_in_ready;
   assign out_hs   = (state == DRAIN) && acc_out_valid && acc_out_ready;
   assign next_ptr = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   assign rsp_data = acc_out_data;

   // Route the granted requester's streams to the accelerator; everyone else sees idle handshakes.
   always_comb begin
      req_ready     = '0;
      rsp_valid     = '0;
      acc_in_valid  = 1'b0;
      acc_in_data   = '0;
      acc_out_ready = 1'b0;
      if (state == FEED) begin
         acc_in_valid       = req_valid[gnt_idx];
         acc_in_data        = req_data[gnt_idx*DATA_W +: DATA_W];
         req_ready[gnt_idx] = acc_in_ready;
      end
      if (state == DRAIN) begin
         rsp_valid[gnt_idx] = acc_out_valid;
         acc_out_ready      = rsp_ready[gnt_idx];
      end
   end

   // Job sequencing: grant in ARB, count input beats in FEED, output beats in DRAIN, then rotate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB;
         rr_ptr    <= '0;
         gnt_idx   <= '0;
         ser_lat   <= '0;
         deser_lat <= '0;
         s_cnt     <= '0;
         d_cnt     <= '0;
      end else begin
         case (state)
            ARB: begin
               if (pick_found) begin
                  gnt_idx   <= pick_idx;
                  ser_lat   <= (ser_ratio == '0) ? 16'd1 : ser_ratio;
                  deser_lat <= deser_ratio;
                  s_cnt     <= '0;
                  d_cnt     <= '0;
                  state     <= FEED;
               end
            end
            FEED: begin
               if (in_hs) begin
                  s_cnt <= s_cnt + 16'd1;
                  if (s_cnt + 16'd1 == ser_lat) begin
                     if (deser_lat == '0) begin
                        state  <= ARB;
                        rr_ptr <= next_ptr;
                     end else begin
                        state <= DRAIN;
                     end
                  end
               end
            end
            DRAIN: begin
               if (out_hs) begin
                  d_cnt <= d_cnt + 16'd1;
                  if (d_cnt + 16'd1 == deser_lat) begin
                     state  <= ARB;
                     rr_ptr <= next_ptr;
                  end
               end
            end
            default: state <= ARB;
         endcase
         // A stalled job is abandoned and the grant moves on.
         if (wd_expire) begin
            state  <= ARB;
            rr_ptr <= next_ptr;
         end
      end
   end

`ifdef ACC_SHARE_ARB_TIMEOUT_EN
   logic [31:0] wd_cnt;

   assign wd_expire = busy && !in_hs && !out_hs && (wd_cnt + 32'd1 >= 32'(TIMEOUT_CYC));

   // Count consecutive busy cycles without progress; flag is sticky until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt      <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (!busy || in_hs || out_hs || wd_expire) wd_cnt <= '0;
         else                                       wd_cnt <= wd_cnt + 32'd1;
         if (wd_expire) err_timeout <= 1'b1;
      end
   end
`else
   assign wd_expire   = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/acc_share_arbiter.md
Name: acc_share_arbiter

Overview:
- Shares one accelerator tile (consumer/producer valid-ready streams plus serialization/deserialization ratios) among N_REQ requesters.
- Round-robin, job-granular arbitration: the granted requester owns the accelerator input for exactly ser_ratio beats and its output for exactly deser_ratio beats, then the grant rotates.
- Sits between the fifo_controller request streams and a single acc unit instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 64, stream data width.
- TIMEOUT_CYC, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ser_ratio  in  16  input beats per job.
- deser_ratio  in  16  output beats per job.
- req_valid  in  N_REQ  per-requester input valid.
- req_ready  out  N_REQ  per-requester input ready.
- req_data  in  N_REQ*DATA_W  packed requester data; requester i occupies slice i.
- rsp_valid  out  N_REQ  per-requester output valid.
- rsp_ready  in  N_REQ  per-requester output ready.
- rsp_data  out  DATA_W  accelerator output, broadcast to all requesters.
- acc_in_valid / acc_in_ready / acc_in_data  out/in/out  1/1/DATA_W  accelerator consumer stream.
- acc_out_valid / acc_out_ready / acc_out_data  in/out/in  1/1/DATA_W  accelerator producer stream.
- busy  out  1  high in FEED and DRAIN.
- gnt_idx  out  $clog2(N_REQ)  current or most recent grant.
- err_timeout  out  1  sticky watchdog flag; tied 0 without the optional feature.

Behaviour:
- Reset (async assert, sync deassert use): state=ARB, rr_ptr=0, gnt_idx=0, counters=0, err_timeout=0. All ready/valid outputs are 0; acc_in_data=0.
- State ARB:
  - Pick the first asserted req_valid searching from rr_ptr upward, wrapping.
  - On a pick: register gnt_idx. Latch ser_ratio and deser_ratio; 0 is coerced to 1 for ser and kept as 0 for deser. Clear s_cnt and d_cnt. Go to FEED.
  - No data transfers in ARB, which gives a 1-cycle bubble per job.
- State FEED:
  - acc_in_valid=req_valid[g], acc_in_data=req_data[g], req_ready[g]=acc_in_ready. All other req_ready are 0.
  - Pass-through is combinational, zero latency.
  - Each handshake increments s_cnt. On the handshake where s_cnt+1==ser_lat:
    - deser_lat==0: go to ARB and set rr_ptr=g+1 mod N_REQ.
    - otherwise: go to DRAIN.
- State DRAIN:
  - rsp_valid[g]=acc_out_valid, acc_out_ready=rsp_ready[g]. Other rsp_valid are 0.
  - Each handshake increments d_cnt. On the handshake where d_cnt+1==deser_lat, go to ARB and set rr_ptr=g+1 mod N_REQ.
- acc_out_ready=0 outside DRAIN. Stray accelerator output during FEED or ARB is stalled, never dropped.
- The grant is locked for the whole job. A requester that drops valid mid-FEED stalls the job; no re-arbitration occurs.
- Ratio inputs changing mid-job are ignored until the next ARB.
- 16-bit counters are compared against the latched ratios only, so no wrap occurs. Maximum 65535 beats per phase.
- Combinational paths: req_valid→acc_in_valid, acc_in_ready→req_ready, acc_out_valid→rsp_valid, rsp_ready→acc_out_ready. There are no ready→valid loops.

Optional Feature:
- Macro: ACC_SHARE_ARB_TIMEOUT_EN.
- When defined:
  - A 32-bit wd_cnt resets on every handshake in FEED or DRAIN and increments otherwise while busy.
  - When wd_cnt reaches TIMEOUT_CYC: set err_timeout (sticky until reset), abort to ARB, advance rr_ptr.
- When undefined: no watchdog logic; err_timeout is constant 0.

Decomposition:
- Package acc_arb_pkg holds:
  - typedef enum logic [1:0] {ARB, FEED, DRAIN} arb_state_t
  - ratio_t (logic [15:0])
  - a helper function rr_pick(valid, ptr) returning index and found.
- One sub-module, acc_rr_picker: combinational round-robin priority pick over N_REQ, parameterised by N_REQ.

Test Plan:
- N_REQ=4, ser=3, deser=2, only req1 valid with data A,B,C:
  - acc_in sees A,B,C.
  - Two acc outputs appear only on rsp_valid[1].
  - gnt_idx=1; rr_ptr becomes 2.
- All four requesters continuously valid, ser=1, deser=1, acc always ready: grant order 0,1,2,3,0 with exactly one idle ARB cycle between jobs.
- ser=0, deser=0: each job is one input beat and no DRAIN. Any acc_out_valid stays unacknowledged (acc_out_ready=0).
- Change ser_ratio 4→2 during FEED after beat 1: job still consumes 4 beats; the next job consumes 2.
- Assert rst_n=0 mid-DRAIN (d_cnt=1 of 3): all outputs go to 0 immediately, state=ARB, rr_ptr=0, and the first grant after release goes to the lowest valid index.
- With ACC_SHARE_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, acc_out_valid held 0 in DRAIN: err_timeout rises after 16 idle cycles, the arbiter returns to ARB, and the next requester is served.
